// File: rtl/field_lock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | field_lock_ctrl                                                           |
// | Locks a falling tetromino into the 20x20 playfield background:            |
// | collision walk, piece write, full-row removal.                            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module field_lock_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clear_field,
    input  logic [4:0]   block_pos_x,
    input  logic [4:0]   block_pos_y,
    input  logic [1:0]   rotate,
    input  logic [15:0]  block_matrix,
    output logic [399:0] field_background,
    output logic         busy,
    output logic         done,
    output logic         collide,
    output logic [2:0]   lines_cleared
);

    localparam int C_COLS = 20;
    localparam int C_ROWS = 20;

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_CHECK = 3'd1;
    localparam logic [2:0] C_ST_WRITE = 3'd2;
    localparam logic [2:0] C_ST_CLEAR = 3'd3;
    localparam logic [2:0] C_ST_DONE  = 3'd4;

    logic [2:0]   r_state;
    logic [2:0]   w_state_nxt;
    logic [3:0]   r_k;
    logic [4:0]   r_row;
    logic [4:0]   r_pos_x;
    logic [4:0]   r_pos_y;
    logic [1:0]   r_rot;
    logic [15:0]  r_matrix;
    logic         r_hit;
    logic [399:0] r_field;
    logic         r_collide;
    logic [2:0]   r_lines;

    logic [1:0]   w_bx;
    logic [1:0]   w_by;
    logic [3:0]   w_src_idx;
    logic         w_src_bit;
    logic [5:0]   w_fx;
    logic [5:0]   w_fy;
    logic [8:0]   w_idx;
    logic         w_in_range;
    logic         w_hit;
    logic         w_last;
    logic [8:0]   w_row_base;
    logic         w_row_full;
    logic [399:0] w_shifted;

    assign w_bx   = r_k[1:0];
    assign w_by   = r_k[3:2];
    assign w_last = (r_k == 4'd15);

    // 3-b for a 2-bit coordinate is just its bitwise inverse
    always_comb begin
        w_src_idx = {w_by, w_bx};
        case (r_rot)
            2'd0:    w_src_idx = {w_by, w_bx};
            2'd1:    w_src_idx = {~w_bx, w_by};
            2'd2:    w_src_idx = {~w_by, ~w_bx};
            2'd3:    w_src_idx = {w_bx, ~w_by};
            default: w_src_idx = {w_by, w_bx};
        endcase
    end

    assign w_src_bit  = r_matrix[w_src_idx];
    assign w_fx       = {1'b0, r_pos_x} + {4'b0, w_bx};
    assign w_fy       = {1'b0, r_pos_y} + {4'b0, w_by};
    assign w_idx      = {3'b0, w_fy} * 9'd20 + {3'b0, w_fx};
    assign w_in_range = (w_fx < 6'd20) && (w_fy < 6'd20);
    assign w_hit      = w_src_bit && (!w_in_range || r_field[w_idx]);

    assign w_row_base = {4'b0, r_row} * 9'd20;
    assign w_row_full = &r_field[w_row_base +: C_COLS];

    // Rows 1..r drop by one, row 0 refills empty; rows below r are untouched
    for (genvar y = 0; y < C_ROWS; y++) begin : g_row
        if (y == 0) begin : g_top
            assign w_shifted[0 +: C_COLS] = '0;
        end else begin : g_body
            assign w_shifted[y*C_COLS +: C_COLS] = (r_row >= 5'(y)) ?
                r_field[(y-1)*C_COLS +: C_COLS] : r_field[y*C_COLS +: C_COLS];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (!clear_field && start) w_state_nxt = C_ST_CHECK;
            end
            C_ST_CHECK: begin
                if (w_last) w_state_nxt = (r_hit || w_hit) ? C_ST_DONE : C_ST_WRITE;
            end
            C_ST_WRITE: begin
                if (w_last) w_state_nxt = C_ST_CLEAR;
            end
            C_ST_CLEAR: begin
                if (!w_row_full && (r_row == 5'd0)) w_state_nxt = C_ST_DONE;
            end
            C_ST_DONE: begin
                w_state_nxt = C_ST_IDLE;
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state != C_ST_IDLE);
        done = (r_state == C_ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k       <= 4'd0;
            r_row     <= 5'd0;
            r_pos_x   <= 5'd0;
            r_pos_y   <= 5'd0;
            r_rot     <= 2'd0;
            r_matrix  <= 16'd0;
            r_hit     <= 1'b0;
            r_field   <= '0;
            r_collide <= 1'b0;
            r_lines   <= 3'd0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (clear_field) begin
                        r_field <= '0;
                    end else if (start) begin
                        r_pos_x   <= block_pos_x;
                        r_pos_y   <= block_pos_y;
                        r_rot     <= rotate;
                        r_matrix  <= block_matrix;
                        r_k       <= 4'd0;
                        r_hit     <= 1'b0;
                        r_collide <= 1'b0;
                        r_lines   <= 3'd0;
                    end
                end
                C_ST_CHECK: begin
                    if (w_hit) r_hit <= 1'b1;
                    if (w_last) r_collide <= r_hit || w_hit;
                    r_k <= r_k + 4'd1;
                end
                C_ST_WRITE: begin
                    if (w_src_bit && w_in_range) r_field[w_idx] <= 1'b1;
                    if (w_last) r_row <= 5'd19;
                    r_k <= r_k + 4'd1;
                end
                C_ST_CLEAR: begin
                    // A full row keeps r so the row shifted into it is tested next
                    if (w_row_full) begin
                        r_field <= w_shifted;
                        r_lines <= r_lines + 3'd1;
                    end else if (r_row != 5'd0) begin
                        r_row <= r_row - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign field_background = r_field;
    assign collide          = r_collide;
    assign lines_cleared    = r_lines;

endmodule
`default_nettype wire

// File: tb/tb_field_lock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_field_lock_ctrl                                                        |
// | Directed scoreboard bench for the playfield lock sequencer.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_field_lock_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic         clear_field;
    logic [4:0]   block_pos_x;
    logic [4:0]   block_pos_y;
    logic [1:0]   rotate;
    logic [15:0]  block_matrix;
    logic [399:0] field_background;
    logic         busy;
    logic         done;
    logic         collide;
    logic [2:0]   lines_cleared;

    field_lock_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .clear_field      (clear_field),
        .block_pos_x      (block_pos_x),
        .block_pos_y      (block_pos_y),
        .rotate           (rotate),
        .block_matrix     (block_matrix),
        .field_background (field_background),
        .busy             (busy),
        .done             (done),
        .collide          (collide),
        .lines_cleared    (lines_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           lat;
        logic         col;
        logic [2:0]   lines;
        logic [399:0] field;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [399:0] exp_f;

    task automatic check(input string name, input logic [399:0] obs, input logic [399:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic col, input logic [2:0] lines,
                                input logic [399:0] f);
        exp_t e;
        e.lat   = lat;
        e.col   = col;
        e.lines = lines;
        e.field = f;
        return e;
    endfunction

    // Start sampled at edge t; lat counts edges after t until done is seen
    task automatic lock(input logic [4:0] x, input logic [4:0] y, input logic [1:0] rot,
                        input logic [15:0] mat, input exp_t e, input bit hold);
        int   lat;
        bit   seen;
        exp_t got;
        sb.push_back(e);
        block_pos_x  = x;
        block_pos_y  = y;
        rotate       = rot;
        block_matrix = mat;
        start        = 1'b1;
        @(posedge clk); #1;
        check("busy_rise", busy, 1'b1);
        if (hold) begin
            block_pos_x  = 5'd0;
            block_pos_y  = 5'd0;
            rotate       = 2'd2;
            block_matrix = 16'hFFFF;
        end else begin
            start = 1'b0;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        got = sb.pop_front();
        check("done_seen", seen, 1'b1);
        check("done_latency", lat, got.lat);
        check("collide", collide, got.col);
        check("lines_cleared", lines_cleared, got.lines);
        check("field", field_background, got.field);
        @(posedge clk); #1;
        check("busy_fall", busy, 1'b0);
        check("done_pulse", done, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        clear_field  = 1'b0;
        block_pos_x  = 5'd0;
        block_pos_y  = 5'd0;
        rotate       = 2'd0;
        block_matrix = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_field", field_background, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_collide", collide, 1'b0);
        check("rst_lines", lines_cleared, 3'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // O piece at bottom, start held and inputs scrambled while busy
        exp_f = '0;
        exp_f[369] = 1'b1; exp_f[370] = 1'b1; exp_f[389] = 1'b1; exp_f[390] = 1'b1;
        lock(5'd9, 5'd18, 2'd0, 16'h0033, mk(52, 1'b0, 3'd0, exp_f), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("no_relock_busy", busy, 1'b0);
        check("no_relock_field", field_background, exp_f);

        clear_field = 1'b1;
        @(posedge clk); #1;
        clear_field = 1'b0;
        check("clear_field", field_background, '0);
        exp_f = '0;

        // I piece running off the right edge
        lock(5'd17, 5'd0, 2'd0, 16'h000F, mk(16, 1'b1, 3'd0, exp_f), 1'b0);

        // Fill rows 18/19 except columns 0..1 with O pieces
        for (int x = 2; x < 20; x += 2) begin
            exp_f[18*20+x] = 1'b1; exp_f[18*20+x+1] = 1'b1;
            exp_f[19*20+x] = 1'b1; exp_f[19*20+x+1] = 1'b1;
            lock(5'(x), 5'd18, 2'd0, 16'h0033, mk(52, 1'b0, 3'd0, exp_f), 1'b0);
        end
        exp_f = '0;
        lock(5'd0, 5'd18, 2'd0, 16'h0033, mk(54, 1'b0, 3'd2, exp_f), 1'b0);

        // Rotations of a single source cell
        exp_f[3] = 1'b1;
        lock(5'd0, 5'd0, 2'd1, 16'h0001, mk(52, 1'b0, 3'd0, exp_f), 1'b0);
        exp_f[63] = 1'b1;
        lock(5'd0, 5'd0, 2'd2, 16'h0001, mk(52, 1'b0, 3'd0, exp_f), 1'b0);
        exp_f[60] = 1'b1;
        lock(5'd0, 5'd0, 2'd3, 16'h0001, mk(52, 1'b0, 3'd0, exp_f), 1'b0);
        lock(5'd0, 5'd0, 2'd1, 16'h0001, mk(16, 1'b1, 3'd0, exp_f), 1'b0);

        // Reset during WRITE (cycle t+20)
        block_pos_x  = 5'd5;
        block_pos_y  = 5'd5;
        rotate       = 2'd0;
        block_matrix = 16'h0033;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_field", field_background, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_collide", collide, 1'b0);
        check("mid_rst_lines", lines_cleared, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        exp_f = '0;
        exp_f[369] = 1'b1; exp_f[370] = 1'b1; exp_f[389] = 1'b1; exp_f[390] = 1'b1;
        lock(5'd9, 5'd18, 2'd0, 16'h0033, mk(52, 1'b0, 3'd0, exp_f), 1'b0);

        // start together with clear_field: clear wins, start dropped
        block_pos_x  = 5'd0;
        block_pos_y  = 5'd0;
        block_matrix = 16'h0033;
        start        = 1'b1;
        clear_field  = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        clear_field = 1'b0;
        check("clr_start_field", field_background, '0);
        check("clr_start_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("clr_start_busy2", busy, 1'b0);
        check("clr_start_done", done, 1'b0);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
